// File: rtl/tl_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
// State encoding is 2 bits with all four codes in use.
package tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } btn_state_t;

    localparam int DEB_N_DEF = 16;
    localparam int LP_N_DEF  = 64;

    // The debounced level is high whenever the button is considered down.
    function automatic logic is_down(input btn_state_t st);
        return (st == ST_HELD) || (st == ST_DB_REL);
    endfunction

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset asynchronously to 0.
module sync2 (
    input  logic C,
    input  logic R,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounce FSM, sticky request flag and optional long-press detector for an
// active-low pushbutton. Long-press logic is built only with BTN_LONGPRESS_EN.
//
// state       | meaning
// ST_IDLE     | button released and stable
// ST_DB_PRESS | bS high, counting CE ticks before accepting the press
// ST_HELD     | press accepted, button down
// ST_DB_REL   | bS low while held, counting CE ticks before accepting release
module button_conditioner
    import tl_pkg::*;
#(
    parameter int DEB_N = DEB_N_DEF,
    parameter int LP_N  = LP_N_DEF
) (
    input  logic C,
    input  logic R,
    input  logic anB,
    input  logic CE,
    input  logic R_BY,
    output logic BP,
    output logic B,
    output logic LP,
    output logic BD
);

    if (DEB_N < 2 || DEB_N > 255) begin : g_bad_deb_n
        $error("DEB_N must be in 2..255");
    end
    if (LP_N < 2 || LP_N > 255) begin : g_bad_lp_n
        $error("LP_N must be in 2..255");
    end

    localparam logic [7:0] DEB_LAST = 8'(DEB_N - 1);

    logic       bs;
    btn_state_t state;
    btn_state_t next_state;
    logic [7:0] cnt;
    logic [7:0] next_cnt;
    logic       bp_set;
    logic       state_bad;

    sync2 u_sync (
        .C (C),
        .R (R),
        .D (~anB),
        .Q (bs)
    );

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        bp_set     = 1'b0;
        state_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bs) begin
                    next_state = ST_DB_PRESS;
                    next_cnt   = 8'd0;
                end
            end
            ST_DB_PRESS: begin
                if (!bs) begin
                    next_state = ST_IDLE;
                    next_cnt   = 8'd0;
                end else if (CE) begin
                    if (cnt == DEB_LAST) begin
                        next_state = ST_HELD;
                        next_cnt   = 8'd0;
                        bp_set     = 1'b1;
                    end else begin
                        next_cnt = cnt + 8'd1;
                    end
                end
            end
            ST_HELD: begin
                if (!bs) begin
                    next_state = ST_DB_REL;
                    next_cnt   = 8'd0;
                end
            end
            ST_DB_REL: begin
                // A bounce back to pressed resumes the hold without a new BP.
                if (bs) begin
                    next_state = ST_HELD;
                    next_cnt   = 8'd0;
                end else if (CE) begin
                    if (cnt == DEB_LAST) begin
                        next_state = ST_IDLE;
                        next_cnt   = 8'd0;
                    end else begin
                        next_cnt = cnt + 8'd1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = 8'd0;
                state_bad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Set has priority over R_BY sampled on the same edge so no press is lost.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            BP <= 1'b0;
            B  <= 1'b0;
            BD <= 1'b0;
        end else begin
            BP <= bp_set;
            B  <= bp_set | (B & ~R_BY & ~state_bad);
            BD <= is_down(next_state);
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam logic [7:0] LP_LAST = 8'(LP_N - 1);

    logic [7:0] lp_cnt;
    logic       lp_done;

    // Only a fresh press restarts the count; DB_REL->HELD bounces keep it.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            lp_cnt  <= 8'd0;
            lp_done <= 1'b0;
            LP      <= 1'b0;
        end else if (state == ST_DB_PRESS && next_state == ST_HELD) begin
            lp_cnt  <= 8'd0;
            lp_done <= 1'b0;
            LP      <= 1'b0;
        end else if (state == ST_HELD && CE) begin
            if (lp_cnt != LP_LAST) begin
                lp_cnt <= lp_cnt + 8'd1;
            end
            LP <= (lp_cnt == LP_LAST) && !lp_done;
            if (lp_cnt == LP_LAST) begin
                lp_done <= 1'b1;
            end
        end else begin
            LP <= 1'b0;
        end
    end
`else
    assign LP = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEB_N=4, LP_N=8.
module tb_button_conditioner;

    localparam int DEB_N = 4;
    localparam int LP_N  = 8;

    logic C = 1'b0;
    logic R, anB, CE, R_BY;
    logic BP, B, LP, BD;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic anb;
        logic ce;
        logic rby;
        logic bp;
        logic b;
        logic bd;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(.DEB_N(DEB_N), .LP_N(LP_N)) dut (
        .C    (C),
        .R    (R),
        .anB  (anB),
        .CE   (CE),
        .R_BY (R_BY),
        .BP   (BP),
        .B    (B),
        .LP   (LP),
        .BD   (BD)
    );

    always #5 C = ~C;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    function automatic void add(input logic anb, ce, rby, bp, b, bd);
        vec_t v;
        v.anb = anb; v.ce = ce; v.rby = rby;
        v.bp = bp; v.b = b; v.bd = bd;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input logic anb_i, input logic ce_i, input logic rby_i);
        anB  = anb_i;
        CE   = ce_i;
        R_BY = rby_i;
        @(posedge C);
        #1;
    endtask

    initial begin
        logic exp_lp;

        // Press, hold, release, then clear the request.
        for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 1);
        for (int k = 8; k <= 9; k++) add(0, 1, 0, 0, 1, 1);
        for (int k = 10; k <= 15; k++) add(1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        // Short bounce never reaches HELD.
        for (int k = 1; k <= 3; k++) add(0, 1, 0, 0, 0, 0);
        for (int k = 4; k <= 10; k++) add(1, 1, 0, 0, 0, 0);
        // Held press with a 2-cycle release glitch.
        for (int k = 1; k <= 6; k++) add(0, 1, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 1);
        add(0, 1, 0, 0, 1, 1);
        for (int k = 9; k <= 10; k++) add(1, 1, 0, 0, 1, 1);
        for (int k = 11; k <= 16; k++) add(0, 1, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1);
        for (int k = 18; k <= 23; k++) add(1, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);

        R = 1'b1; anB = 1'b1; CE = 1'b1; R_BY = 1'b0;
        repeat (2) @(posedge C);
        #1;
        check("reset_bp", BP, 1'b0);
        check("reset_b", B, 1'b0);
        check("reset_bd", BD, 1'b0);
        check("reset_lp", LP, 1'b0);
        R = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].anb, vecs[i].ce, vecs[i].rby);
            check($sformatf("vec%0d_bp", i), BP, vecs[i].bp);
            check($sformatf("vec%0d_b", i), B, vecs[i].b);
            check($sformatf("vec%0d_bd", i), BD, vecs[i].bd);
`ifndef BTN_LONGPRESS_EN
            check($sformatf("vec%0d_lp", i), LP, 1'b0);
`endif
        end

        // Set wins over a coincident R_BY; R_BY alone clears on the next edge.
        for (int k = 1; k <= 9; k++) begin
            step(0, 1, 0);
            check($sformatf("first_press_e%0d_bp", k), BP, logic'(k == 7));
        end
        check("first_press_b", B, 1'b1);
        repeat (9) step(1, 1, 0);
        check("first_release_bd", BD, 1'b0);
        check("first_release_b", B, 1'b1);
        repeat (6) step(0, 1, 0);
        step(0, 1, 1);
        check("coincide_bp", BP, 1'b1);
        check("coincide_b", B, 1'b1);
        step(0, 1, 1);
        check("clear_after_b", B, 1'b0);
        check("clear_after_bp", BP, 1'b0);
        repeat (9) step(1, 1, 0);
        check("coincide_release_bd", BD, 1'b0);

        // CE every 4th cycle: DB_PRESS entered at edge 3, ticks at 4, 8, 12, 16.
        for (int k = 1; k <= 17; k++) begin
            step(0, logic'(k % 4 == 0), 0);
            check($sformatf("ce4_e%0d_bp", k), BP, logic'(k == 16));
            check($sformatf("ce4_e%0d_bd", k), BD, logic'(k >= 16));
        end
        step(1, 1, 1);
        repeat (8) step(1, 1, 0);
        check("ce4_release_b", B, 1'b0);
        check("ce4_release_bd", BD, 1'b0);

        // Reset mid-DB_PRESS discards the press; the held button re-debounces.
        repeat (4) step(0, 1, 0);
        R = 1'b1;
        #1;
        check("midreset_bp", BP, 1'b0);
        check("midreset_b", B, 1'b0);
        check("midreset_bd", BD, 1'b0);
        check("midreset_lp", LP, 1'b0);
        repeat (2) @(posedge C);
        #1;
        check("midreset_hold_bd", BD, 1'b0);
        R = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(0, 1, 0);
            check($sformatf("redeb_e%0d_bp", k), BP, logic'(k == 7));
            check($sformatf("redeb_e%0d_bd", k), BD, logic'(k == 7));
        end

        // Long press: HELD entered at edge 7, pulse on the 8th CE tick after.
        for (int k = 8; k <= 20; k++) begin
            step(0, 1, 0);
`ifdef BTN_LONGPRESS_EN
            exp_lp = logic'(k == 15);
`else
            exp_lp = 1'b0;
`endif
            check($sformatf("lp_e%0d", k), LP, exp_lp);
        end
        step(1, 1, 1);
        repeat (8) step(1, 1, 0);
        check("final_bd", BD, 1'b0);
        check("final_b", B, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEB_N, default 16: number of CE ticks that bS must stay stable to accept a press or release; legal range 2..255.
REQ-002 Parameter LP_N, default 64: number of CE ticks held in HELD before an LP pulse; legal range 2..255; used only with BTN_LONGPRESS_EN.
REQ-003 C  in  1  sole clock; all state changes on the rising edge.
REQ-004 R  in  1  reset, asynchronous, active-high.
REQ-005 anB  in  1  raw pushbutton, active-low, asynchronous to C.
REQ-006 CE  in  1  debounce tick enable; counters advance only when CE=1.
REQ-007 R_BY  in  1  request clear from the downstream traffic-light controller.
REQ-008 BP  out  1  one-C-cycle pulse on each accepted press.
REQ-009 B  out  1  sticky request flag; set by BP, cleared by R_BY.
REQ-010 LP  out  1  one-C-cycle long-press pulse.
REQ-011 BD  out  1  debounced level; 1 while the FSM is in HELD or DB_REL.

Function
REQ-012 The block SHALL synchronise ~anB through two flops; the second flop output is bS.
REQ-013 The FSM SHALL have states IDLE, DB_PRESS, HELD and DB_REL, with an 8-bit counter cnt.
REQ-014 IDLE: bS=1 -> DB_PRESS with cnt=0; otherwise stay.
REQ-015 DB_PRESS: bS=0 -> IDLE; else if CE=1 and cnt=DEB_N-1 -> HELD; else if CE=1 -> cnt+1.
REQ-016 HELD: bS=0 -> DB_REL with cnt=0; otherwise stay.
REQ-017 DB_REL: bS=1 -> HELD (no new BP); else if CE=1 and cnt=DEB_N-1 -> IDLE; else if CE=1 -> cnt+1.
REQ-018 BP SHALL be registered and high exactly in the first C cycle after the DB_PRESS->HELD transition, never otherwise.
REQ-019 Latency with CE tied 1: if anB is first sampled low at edge 1 and stays low, BP SHALL rise after edge DEB_N+3.
REQ-020 B SHALL be set in the cycle BP is high and hold until R_BY=1 is sampled; if BP and R_BY coincide, B SHALL remain 1 (set wins, so no press is lost).
REQ-021 cnt SHALL never wrap; it saturates at DEB_N-1 (or LP_N-1) by construction of the transitions.
REQ-022 An illegal state encoding SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-023 While R=1: synchroniser flops 0, state IDLE, cnt 0, BP/B/LP/BD 0, long-press counter 0.
REQ-024 Reset asserted mid-debounce or mid-hold SHALL discard the press; after release of R, a press still held SHALL be re-debounced from IDLE.

Configuration
REQ-025 Macro BTN_LONGPRESS_EN defined: a separate 8-bit lp counter SHALL clear on entry to HELD and increment on CE in HELD; LP pulses once when the counter reaches LP_N-1; the counter holds until HELD is left; DB_REL->HELD bounces SHALL NOT restart it.
REQ-026 Macro BTN_LONGPRESS_EN undefined: LP SHALL be tied 0, and no lp counter logic SHALL exist.

Structure
REQ-027 Shared package tl_pkg SHALL hold the FSM state enum (2 bits) and default constants DEB_N_DEF=16 and LP_N_DEF=64.
REQ-028 The two-flop synchroniser SHALL be a sub-module sync2 (ports C, R, D, Q; asynchronous reset to 0).
REQ-029 The FSM, counters, B latch and output registers SHALL live in button_conditioner.

Verification (DEB_N=4, CE=1 unless stated)
REQ-030 anB low from edge 1, held -> BP=1 for one cycle after edge 7; B=1 and BD=1 from then on.
REQ-031 anB low for 3 cycles then high (bounce) -> state returns to IDLE; BP, B and BD stay 0.
REQ-032 Held press, anB high for 2 cycles then low again -> DB_REL->HELD; no second BP; BD stays 1.
REQ-033 B=1 and R_BY=1 in the same cycle as a new BP -> B stays 1; R_BY alone the next cycle -> B=0.
REQ-034 CE pulsed 1 every 4th cycle -> BP delayed accordingly (4 CE ticks in DB_PRESS); R=1 pulsed mid-DB_PRESS -> all outputs 0, re-debounce afterwards.
REQ-035 With BTN_LONGPRESS_EN and LP_N=8, holding the press -> LP pulses once, 8 CE ticks after HELD entry; without the macro, LP=0 throughout.
